// File: rtl/image_pkg.sv
// Shared image geometry and pixel/state types for the loader, the image ROM and the conv layers.
package image_pkg;

  localparam int unsigned IMG_H = 28;
  localparam int unsigned IMG_W = 28;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    WAIT_SOF,
    LOAD,
    FULL
  } loader_state_e;

endpackage

// File: rtl/image_raster_counter.sv
// Row-major raster position: col advances first and wraps at IMG_W-1, then row increments.
module image_raster_counter
  import image_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load_zero,
  input  logic             i_advance,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last
);

  logic [ROW_W-1:0] r_row, w_row_base, w_row_nxt;
  logic [COL_W-1:0] r_col, w_col_base, w_col_nxt;

  // Load-zero is applied before advance, so asserting both lands on (0,1).
  always_comb begin
    w_row_base = i_load_zero ? '0 : r_row;
    w_col_base = i_load_zero ? '0 : r_col;
    w_row_nxt  = w_row_base;
    w_col_nxt  = w_col_base;
    if (i_advance) begin
      if (w_col_base == COL_W'(IMG_W - 1)) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_base + ROW_W'(1);
      end else begin
        w_col_nxt = w_col_base + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));

endmodule

// File: rtl/image_stream_loader.sv
// Fills a 28x28 frame buffer from a serial pixel stream and holds it until the consumer acks.
module image_stream_loader
  import image_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  pixel_t           s_data,
  input  logic             s_sof,
  output pixel_t           image [IMG_H][IMG_W],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             sof_err,
  output logic [CNT_W-1:0] frames_loaded
);

  loader_state_e    r_state, w_state_nxt;
  logic             r_ready, r_frame_valid, r_sof_err;
  logic [CNT_W-1:0] r_frames;
  pixel_t           r_image [IMG_H][IMG_W];

  logic             w_beat, w_load_zero, w_advance, w_wr, w_wr_origin, w_done, w_restart;
  logic             w_last;
  logic [ROW_W-1:0] w_row, w_wr_row;
  logic [COL_W-1:0] w_col, w_wr_col;

  image_raster_counter u_raster (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load_zero(w_load_zero),
    .i_advance  (w_advance),
    .o_row      (w_row),
    .o_col      (w_col),
    .o_last     (w_last)
  );

  assign w_beat = s_valid && r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_zero = 1'b0;
    w_advance   = 1'b0;
    w_wr        = 1'b0;
    w_wr_origin = 1'b0;
    w_done      = 1'b0;
    w_restart   = 1'b0;
    unique case (r_state)
      WAIT_SOF: begin
        if (w_beat && s_sof) begin
          w_wr        = 1'b1;
          w_wr_origin = 1'b1;
          w_load_zero = 1'b1;
          w_advance   = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_beat) begin
          w_wr = 1'b1;
          if (s_sof) begin
            w_wr_origin = 1'b1;
            w_load_zero = 1'b1;
            w_advance   = 1'b1;
            w_restart   = 1'b1;
          end else if (w_last) begin
            // Park the counter at (0,0) rather than stepping past the last row.
            w_load_zero = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = FULL;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      FULL: begin
        if (frame_ack) w_state_nxt = WAIT_SOF;
      end
      default: w_state_nxt = WAIT_SOF;
    endcase
  end

  assign w_wr_row = w_wr_origin ? '0 : w_row;
  assign w_wr_col = w_wr_origin ? '0 : w_col;

  // Handshake flags are registered copies of the next state so they stay low through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= WAIT_SOF;
      r_ready       <= 1'b0;
      r_frame_valid <= 1'b0;
      r_sof_err     <= 1'b0;
      r_frames      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ready       <= (w_state_nxt != FULL);
      r_frame_valid <= (w_state_nxt == FULL);
      r_sof_err     <= w_restart;
      if (w_done) r_frames <= r_frames + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < IMG_H; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          r_image[r][c] <= '0;
        end
      end
    end else if (w_wr) begin
      r_image[w_wr_row][w_wr_col] <= s_data;
    end
  end

  assign image         = r_image;
  assign s_ready       = r_ready;
  assign frame_valid   = r_frame_valid;
  assign sof_err       = r_sof_err;
  assign frames_loaded = r_frames;

endmodule

// File: tb/tb_image_stream_loader.sv
// Randomised bench for image_stream_loader: a frame-level reference model feeds a scoreboard.
module tb_image_stream_loader;
  import image_pkg::*;

  localparam int NPIX = IMG_H * IMG_W;
  localparam int FW   = NPIX * PIX_W;

  typedef struct packed {
    logic [FW-1:0] img;
    logic [15:0]   cnt;
  } exp_frame_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        frame_ack = 1'b0;
  pixel_t      s_data = '0;
  logic        s_ready, frame_valid, sof_err;
  logic [15:0] frames_loaded;
  pixel_t      image [IMG_H][IMG_W];

  always #5 clk = ~clk;

  image_stream_loader #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_sof        (s_sof),
    .image        (image),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .sof_err      (sof_err),
    .frames_loaded(frames_loaded)
  );

  int checks = 0;
  int errors = 0;

  exp_frame_t frame_q [$];
  bit         sof_q [$];

  // Reference model: a flat pixel array filled by a linear beat index.
  logic [PIX_W-1:0] m_img [NPIX];
  bit               m_full, m_in_frame;
  int               m_idx;
  logic [15:0]      m_frames;

  function automatic logic [FW-1:0] model_flat();
    logic [FW-1:0] f;
    for (int i = 0; i < NPIX; i++) f[i*PIX_W +: PIX_W] = m_img[i];
    return f;
  endfunction

  function automatic logic [FW-1:0] dut_flat();
    logic [FW-1:0] f;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) f[(r*IMG_W + c)*PIX_W +: PIX_W] = image[r][c];
    return f;
  endfunction

  function automatic logic [FW-1:0] const_flat(input logic [PIX_W-1:0] v);
    logic [FW-1:0] f;
    for (int i = 0; i < NPIX; i++) f[i*PIX_W +: PIX_W] = v;
    return f;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic img_chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    int bad;
    int first;
    bad = 0;
    first = -1;
    checks++;
    for (int i = 0; i < NPIX; i++) begin
      if (act[i*PIX_W +: PIX_W] !== exp[i*PIX_W +: PIX_W]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s mismatches=%0d first_idx=%0d got=%0d expected=%0d", name, bad, first,
               $signed(act[first*PIX_W +: PIX_W]), $signed(exp[first*PIX_W +: PIX_W]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) m_img[i] = '0;
    m_full = 0;
    m_in_frame = 0;
    m_idx = 0;
    m_frames = '0;
    frame_q.delete();
    sof_q.delete();
  endtask

  task automatic model_step(input bit v, input logic [PIX_W-1:0] d, input bit sof, input bit ack);
    exp_frame_t e;
    if (v && !m_full) begin
      if (sof) begin
        if (m_in_frame) sof_q.push_back(1'b1);
        m_img[0] = d;
        m_idx = 1;
        m_in_frame = 1;
      end else if (m_in_frame) begin
        m_img[m_idx] = d;
        m_idx++;
        if (m_idx == NPIX) begin
          m_in_frame = 0;
          m_full = 1;
          m_frames++;
          e.img = model_flat();
          e.cnt = m_frames;
          frame_q.push_back(e);
        end
      end
    end else if (m_full && ack) begin
      m_full = 0;
    end
  endtask

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic drive(input bit v, input logic [PIX_W-1:0] d, input bit sof, input bit ack);
    s_valid = v;
    s_data = d;
    s_sof = sof;
    frame_ack = ack;
    model_step(v, d, sof, ack);
    @(negedge clk);
  endtask

  function automatic logic [PIX_W-1:0] pixval(input int mode, input int i);
    logic [PIX_W-1:0] v;
    case (mode)
      0:       v = PIX_W'(i % 128);
      1:       v = PIX_W'($urandom_range(0, 255));
      default: v = 8'hFB;
    endcase
    return v;
  endfunction

  task automatic send_frame(input int mode, input bit gaps, input int ack_at);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) drive(1'b0, '0, 1'b0, 1'b0);
      if (i == NPIX - 1) chk("fv_low_before_last", frame_valid, 0);
      drive(1'b1, pixval(mode, i), i == 0, i == ack_at);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_sof = 1'b0;
    frame_ack = 1'b0;
    model_reset();
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_sof_err", sof_err, 0);
    chk("rst_frames_loaded", frames_loaded, m_frames);
    img_chk("rst_image", dut_flat(), model_flat());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_release", s_ready, 1);
  endtask

  // Scoreboard monitor: pops an expected frame whenever frame_valid rises.
  logic       fv_prev = 1'b0;
  exp_frame_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (frame_valid && !fv_prev) begin
        chk("frame_expected", frame_q.size() > 0, 1);
        if (frame_q.size() > 0) begin
          mon_e = frame_q.pop_front();
          img_chk("frame_image", dut_flat(), mon_e.img);
          chk("frame_count", frames_loaded, mon_e.cnt);
        end
      end
      if (sof_err) begin
        chk("sof_err_expected", sof_q.size() > 0, 1);
        if (sof_q.size() > 0) void'(sof_q.pop_front());
      end
      fv_prev = frame_valid;
    end
  end

  initial begin
    #1;
    // Gap-free ROM-pattern frame
    do_reset();
    send_frame(0, 1'b0, -1);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_s_ready", s_ready, 0);
    chk("t1_frames", frames_loaded, m_frames);

    // Ack, same frame with gaps, then beats offered while FULL
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t2_ack_fv", frame_valid, 0);
    chk("t2_ack_ready", s_ready, 1);
    send_frame(0, 1'b1, -1);
    for (int k = 0; k < 10; k++) begin
      chk("t2_full_ready", s_ready, 0);
      drive(1'b1, PIX_W'($urandom_range(0, 255)), k == 0, 1'b0);
    end
    img_chk("t2_full_hold", dut_flat(), model_flat());
    chk("t2_fv_hold", frame_valid, 1);
    chk("t2_frames", frames_loaded, m_frames);

    // Non-SOF beats before the first SOF are discarded
    do_reset();
    for (int k = 0; k < 5; k++) drive(1'b1, PIX_W'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("t3_still_idle", frame_valid, 0);
    send_frame(1, 1'b0, -1);
    chk("t3_origin", image[0][0], $signed(m_img[0]));

    // Abort at beat 300 with a fresh SOF, then a constant -5 frame
    do_reset();
    for (int k = 0; k < 300; k++) drive(1'b1, PIX_W'($urandom_range(0, 255)), k == 0, 1'b0);
    send_frame(2, 1'b1, -1);
    img_chk("t4_all_minus5", dut_flat(), const_flat(8'hFB));
    chk("t4_frames", frames_loaded, 1);

    // Back-to-back frame after ack, with an ignored ack mid-load
    drive(1'b0, '0, 1'b0, 1'b1);
    chk("t5_ack_fv", frame_valid, 0);
    chk("t5_ack_ready", s_ready, 1);
    send_frame(1, 1'b1, 100);
    chk("t5_frames", frames_loaded, 2);

    // Asynchronous reset mid-frame
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 400; k++) drive(1'b1, PIX_W'($urandom_range(0, 255)), k == 0, 1'b0);
    #3;
    do_reset();
    repeat (3) drive(1'b0, '0, 1'b0, 1'b0);
    chk("t6_frames", frames_loaded, 0);
    chk("t6_fv", frame_valid, 0);

    chk("frames_pending", frame_q.size(), 0);
    chk("sof_err_pending", sof_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
